// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: receiving-end checker for the VGA output.
// Recovers pixel coordinates from hsync/vsync, checks line and frame lengths,
// tracks timing lock and counts lit active pixels per frame.
// Optional per-frame CRC-16-CCITT of the active image: define VGA_MON_CRC_EN.
module vga_sync_monitor #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned V_ACTIVE    = 480,
    parameter logic        SYNC_POL    = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk_12MHz,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        red,
    input  logic        green,
    input  logic        blue,
    input  logic        err_clr,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        pixel_valid,
    output logic        locked,
    output logic        frame_done,
    output logic [18:0] lit_count,
    output logic        err_hlen,
    output logic        err_vlen
`ifdef VGA_MON_CRC_EN
    ,
    output logic [15:0] frame_crc
`endif
);

    localparam logic [10:0] H_LEN  = 11'(H_TOTAL);
    localparam logic [10:0] V_LEN  = 11'(V_TOTAL);
    localparam logic [9:0]  HX0    = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  HX1    = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0]  VY0    = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  VY1    = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam int unsigned TW     = $clog2(2 * H_TOTAL);
    localparam logic [TW-1:0] TO_MAX = TW'(2 * H_TOTAL - 1);
    localparam int unsigned GW     = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t          state, state_n;
    logic [GW-1:0]   good, good_n;

    logic            hs_r, hs_p, vs_r, vs_p;
    logic [2:0]      rgb_r, rgb_p;
    logic [9:0]      hcnt, vcnt;
    logic [TW-1:0]   idle;
    logic            vpend, h_armed, frame_armed, frame_bad;
    logic [18:0]     acc;

    logic            edge_h, edge_v, boundary, in_win, lit_px;
    logic            h_err, v_err, timeout, bad_now;

    // Sync and colour are sampled once; edge detection needs the previous
    // sample, so the colour gets a second stage to stay aligned with hcnt.
    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            hs_r  <= ~SYNC_POL;
            hs_p  <= ~SYNC_POL;
            vs_r  <= ~SYNC_POL;
            vs_p  <= ~SYNC_POL;
            rgb_r <= '0;
            rgb_p <= '0;
        end else if (pix_en) begin
            hs_r  <= hsync;
            hs_p  <= hs_r;
            vs_r  <= vsync;
            vs_p  <= vs_r;
            rgb_r <= {red, green, blue};
            rgb_p <= rgb_r;
        end
    end

    assign edge_h   = pix_en && (hs_r == SYNC_POL) && (hs_p != SYNC_POL);
    assign edge_v   = pix_en && (vs_r == SYNC_POL) && (vs_p != SYNC_POL);
    assign boundary = edge_h && (vpend || edge_v);
    assign frame_done = boundary && frame_armed;

    assign in_win = (state != SEARCH) && (hcnt >= HX0) && (hcnt < HX1)
                 && (vcnt >= VY0) && (vcnt < VY1);
    assign pixel_valid = in_win;
    assign x      = in_win ? (hcnt - HX0) : '0;
    assign y      = in_win ? (vcnt - VY0) : '0;
    assign lit_px = in_win && (|rgb_p);

    assign h_err   = edge_h && h_armed && (({1'b0, hcnt} + 11'd1) != H_LEN);
    assign v_err   = frame_done && (({1'b0, vcnt} + 11'd1) != V_LEN);
    assign timeout = pix_en && !edge_h && (idle == TO_MAX);
    assign bad_now = frame_bad || h_err || v_err;
    assign locked  = (state == LOCKED);

    // Line/frame counters, arming flags and the lit-pixel accumulator.
    // A timeout disarms both checks so the first boundaries after
    // reacquisition are measured but never flagged.
    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            hcnt        <= '0;
            vcnt        <= '0;
            idle        <= '0;
            vpend       <= 1'b0;
            h_armed     <= 1'b0;
            frame_armed <= 1'b0;
            frame_bad   <= 1'b0;
            acc         <= '0;
            lit_count   <= '0;
        end else if (pix_en) begin
            if (edge_h) begin
                hcnt    <= '0;
                idle    <= '0;
                h_armed <= 1'b1;
            end else begin
                if (hcnt != '1)   hcnt <= hcnt + 10'd1;
                if (idle != TO_MAX) idle <= idle + TW'(1);
            end
            if (boundary) begin
                vcnt        <= '0;
                vpend       <= 1'b0;
                frame_armed <= 1'b1;
                frame_bad   <= 1'b0;
                acc         <= '0;
            end else begin
                if (edge_v) vpend <= 1'b1;
                if (edge_h && (vcnt != '1)) vcnt <= vcnt + 10'd1;
                if (h_err) frame_bad <= 1'b1;
                if (lit_px) acc <= acc + 19'd1;
            end
            if (frame_done) lit_count <= acc + {18'd0, lit_px};
            if (timeout) begin
                h_armed     <= 1'b0;
                frame_armed <= 1'b0;
                vpend       <= 1'b0;
            end
        end
    end

    // Sticky length errors; a new error outranks a simultaneous clear.
    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            err_hlen <= 1'b0;
            err_vlen <= 1'b0;
        end else begin
            if (h_err)        err_hlen <= 1'b1;
            else if (err_clr) err_hlen <= 1'b0;
            if (v_err)        err_vlen <= 1'b1;
            else if (err_clr) err_vlen <= 1'b0;
        end
    end

    // Lock state register.
    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            state <= SEARCH;
            good  <= '0;
        end else begin
            state <= state_n;
            good  <= good_n;
        end
    end

    // Lock next-state: count clean frames in ACQUIRE, drop on errors or
    // on loss of hsync.
    always_comb begin
        state_n = state;
        good_n  = good;
        if (timeout) begin
            state_n = SEARCH;
            good_n  = '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (edge_v) begin
                        state_n = ACQUIRE;
                        good_n  = '0;
                    end
                end
                ACQUIRE: begin
                    if (frame_done) begin
                        if (bad_now) begin
                            good_n = '0;
                        end else begin
                            good_n = good + GW'(1);
                            if ((good + GW'(1)) == GW'(LOCK_FRAMES)) state_n = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (h_err || v_err) begin
                        state_n = ACQUIRE;
                        good_n  = '0;
                    end
                end
                default: begin
                    state_n = SEARCH;
                    good_n  = '0;
                end
            endcase
        end
    end

`ifdef VGA_MON_CRC_EN
    logic [15:0] crc;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [2:0] d);
        logic [15:0] r;
        r = c;
        for (int unsigned i = 0; i < 3; i++) begin
            if (r[15] ^ d[2 - i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else                  r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // Running image CRC, restarted at each frame boundary and published
    // with frame_done (including the pixel of that cycle).
    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            crc       <= 16'hFFFF;
            frame_crc <= 16'h0000;
        end else if (pix_en) begin
            if (boundary)    crc <= 16'hFFFF;
            else if (in_win) crc <= crc_step(crc, rgb_p);
            if (frame_done)  frame_crc <= in_win ? crc_step(crc, rgb_p) : crc;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed bench for vga_sync_monitor with a reduced
// 16x12 raster (10x8 active). Define VGA_MON_CRC_EN to also check frame_crc.
module tb_vga_sync_monitor;

    logic        clk_12MHz = 1'b0;
    logic        reset, pix_en, hsync, vsync, red, green, blue, err_clr;
    logic [9:0]  x, y;
    logic        pixel_valid, locked, frame_done, err_hlen, err_vlen;
    logic [18:0] lit_count;
`ifdef VGA_MON_CRC_EN
    logic [15:0] frame_crc;
    logic [15:0] gold_crc;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          fd_seen = 0;

    always #5 clk_12MHz = ~clk_12MHz;

    vga_sync_monitor #(
        .H_TOTAL(16), .H_SYNC(2), .H_BP(2), .H_ACTIVE(10),
        .V_TOTAL(12), .V_SYNC(1), .V_BP(1), .V_ACTIVE(8),
        .SYNC_POL(1'b0), .LOCK_FRAMES(2)
    ) dut (
        .clk_12MHz(clk_12MHz), .reset(reset), .pix_en(pix_en),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .err_clr(err_clr), .x(x), .y(y), .pixel_valid(pixel_valid),
        .locked(locked), .frame_done(frame_done), .lit_count(lit_count),
        .err_hlen(err_hlen), .err_vlen(err_vlen)
`ifdef VGA_MON_CRC_EN
        , .frame_crc(frame_crc)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

`ifdef VGA_MON_CRC_EN
    function automatic logic [15:0] crc_pix(input logic [15:0] c, input logic [2:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 2; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction
`endif

    // One pixel period: drive inputs, clock, sample 1 time unit later.
    task automatic pix(input logic hs, input logic vs, input logic w);
        hsync = hs;
        vsync = vs;
        red   = w;
        green = w;
        blue  = w;
        @(posedge clk_12MHz);
        #1;
        if (frame_done) fd_seen++;
    endtask

    // Lines first_l..last_l-1 of a frame. Hsync active on pixels 0-1, vsync
    // on line 0. short_l is sent with 15 pixels. Outputs seen after pixel p
    // describe pixel p-1 (one stage of input registering).
    task automatic frame(input string tag, input int first_l, input int last_l,
                         input int short_l, input bit white, input int lit_v,
                         input int lit_h, input bit clr, input bit probe,
                         input int exp_fd);
        int len;
        fd_seen = 0;
        for (int l = first_l; l < last_l; l++) begin
            len = (l == short_l) ? 15 : 16;
            for (int p = 0; p < len; p++) begin
                err_clr = clr && (l == first_l) && (p == 0);
                pix((p < 2) ? 1'b0 : 1'b1, (l < 1) ? 1'b0 : 1'b1,
                    white || ((l == lit_v) && (p == lit_h)));
                if (probe && l == 5) begin
                    if (p == 4) check({tag, ".pv_h3"}, 32'(pixel_valid), 0);
                    if (p == 5) begin
                        check({tag, ".pv_h4"}, 32'(pixel_valid), 1);
                        check({tag, ".x_h4"}, 32'(x), 0);
                    end
                    if (p == 8) begin
                        check({tag, ".pv_h7"}, 32'(pixel_valid), 1);
                        check({tag, ".x_h7"}, 32'(x), 3);
                        check({tag, ".y_v5"}, 32'(y), 3);
                    end
                    if (p == 14) check({tag, ".x_h13"}, 32'(x), 9);
                    if (p == 15) check({tag, ".pv_h14"}, 32'(pixel_valid), 0);
                end
            end
        end
        err_clr = 1'b0;
        check({tag, ".fd"}, 32'(fd_seen), 32'(exp_fd));
    endtask

    initial begin
        reset = 1'b1; pix_en = 1'b1; err_clr = 1'b0;
        hsync = 1'b1; vsync = 1'b1; red = 1'b0; green = 1'b0; blue = 1'b0;
`ifdef VGA_MON_CRC_EN
        gold_crc = 16'hFFFF;
        for (int i = 0; i < 80; i++) gold_crc = crc_pix(gold_crc, 3'b111);
`endif
        repeat (3) @(posedge clk_12MHz);
        #1;
        check("rst.pv", 32'(pixel_valid), 0);
        check("rst.xy", 32'({x, y}), 0);
        check("rst.locked", 32'(locked), 0);
        check("rst.fd", 32'(frame_done), 0);
        check("rst.lit", 32'(lit_count), 0);
        check("rst.errs", 32'({err_hlen, err_vlen}), 0);
        reset = 1'b0;

        // Nominal white frames; first boundary after reset is unmeasured.
        frame("f0", 0, 12, -1, 1, -1, -1, 0, 0, 0);
        check("f0.locked", 32'(locked), 0);
        frame("f1", 0, 12, -1, 1, -1, -1, 0, 0, 1);
        check("f1.lit", 32'(lit_count), 80);
        check("f1.locked", 32'(locked), 0);
`ifdef VGA_MON_CRC_EN
        check("f1.crc", 32'(frame_crc), 32'(gold_crc));
`endif
        frame("f2", 0, 12, -1, 1, -1, -1, 0, 0, 1);
        check("f2.locked", 32'(locked), 1);
        frame("f3", 0, 12, -1, 1, -1, -1, 0, 0, 1);
        check("f3.lit", 32'(lit_count), 80);
        check("f3.errs", 32'({err_hlen, err_vlen}), 0);

        // Single lit pixel at hcnt=7, vcnt=5.
        frame("f4", 0, 12, -1, 0, 5, 7, 0, 1, 1);
        // Short line 3 while locked.
        frame("f5", 0, 12, 3, 1, -1, -1, 0, 0, 1);
        check("f5.lit", 32'(lit_count), 1);
        check("f5.err_hlen", 32'(err_hlen), 1);
        check("f5.err_vlen", 32'(err_vlen), 0);
        check("f5.locked", 32'(locked), 0);
        frame("f6", 0, 12, -1, 1, -1, -1, 0, 0, 1);
        check("f6.lit", 32'(lit_count), 80);
        check("f6.locked", 32'(locked), 0);
        frame("f7", 0, 12, -1, 1, -1, -1, 0, 0, 1);
        check("f7.locked", 32'(locked), 0);
        frame("f8", 0, 12, -1, 1, -1, -1, 0, 0, 1);
        check("f8.locked", 32'(locked), 1);
        frame("f9", 0, 12, -1, 1, -1, -1, 1, 0, 1);
        check("f9.err_hlen", 32'(err_hlen), 0);
        check("f9.locked", 32'(locked), 1);

        // 11-line frame.
        frame("f10", 0, 11, -1, 1, -1, -1, 0, 0, 1);
        check("f10.err_vlen", 32'(err_vlen), 0);
        frame("f11", 0, 12, -1, 1, -1, -1, 0, 0, 1);
        check("f11.err_vlen", 32'(err_vlen), 1);
        check("f11.err_hlen", 32'(err_hlen), 0);
        check("f11.locked", 32'(locked), 0);
        frame("f12", 0, 12, -1, 1, -1, -1, 1, 0, 1);
        check("f12.err_vlen", 32'(err_vlen), 0);
        check("f12.locked", 32'(locked), 0);
        frame("f13", 0, 12, -1, 1, -1, -1, 0, 0, 1);
        check("f13.locked", 32'(locked), 1);

        // Loss of hsync for 40 pixels.
        fd_seen = 0;
        for (int i = 0; i < 40; i++) pix(1'b1, 1'b1, 1'b1);
        check("loss.locked", 32'(locked), 0);
        check("loss.pv", 32'(pixel_valid), 0);
        check("loss.fd", 32'(fd_seen), 0);
        check("loss.errs", 32'({err_hlen, err_vlen}), 0);
        frame("f14", 0, 12, -1, 1, -1, -1, 0, 0, 0);
        check("f14.errs", 32'({err_hlen, err_vlen}), 0);
        frame("f15", 0, 12, -1, 1, -1, -1, 0, 0, 1);
        check("f15.lit", 32'(lit_count), 80);
        check("f15.locked", 32'(locked), 0);
        frame("f16", 0, 12, -1, 1, -1, -1, 0, 0, 1);
        check("f16.locked", 32'(locked), 1);

        // Reset in the middle of a frame while locked.
        frame("f17a", 0, 6, -1, 1, -1, -1, 0, 0, 1);
        reset = 1'b1;
        #1;
        check("mrst.locked", 32'(locked), 0);
        check("mrst.lit", 32'(lit_count), 0);
        check("mrst.pvxy", 32'({pixel_valid, x, y}), 0);
        check("mrst.fd", 32'(frame_done), 0);
`ifdef VGA_MON_CRC_EN
        check("mrst.crc", 32'(frame_crc), 0);
`endif
        @(posedge clk_12MHz);
        #1;
        reset = 1'b0;
        frame("f17b", 6, 12, -1, 1, -1, -1, 0, 0, 0);
        check("f17b.pv", 32'(pixel_valid), 0);
        frame("f18", 0, 12, -1, 1, -1, -1, 0, 0, 0);
        frame("f19", 0, 12, -1, 1, -1, -1, 0, 0, 1);
        check("f19.lit", 32'(lit_count), 80);
        check("f19.locked", 32'(locked), 0);
`ifdef VGA_MON_CRC_EN
        check("f19.crc", 32'(frame_crc), 32'(gold_crc));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
